// File: rtl/frame_pattern_generator_if.sv
`default_nettype none
// ============================================================================
// frame_pattern_generator_if : AXI-Stream-style pixel bus (data/valid/ready/last/user)
// Revision: 1.0
// ============================================================================
interface frame_pattern_generator_if #(
   parameter int DATA_BITS = 24
);
   logic [DATA_BITS-1:0] m_data;
   logic                 m_valid;
   logic                 m_ready;
   logic                 m_last;
   logic                 m_user;

   modport master (output m_data, m_valid, m_last, m_user, input m_ready);
   modport slave  (input m_data, m_valid, m_last, m_user, output m_ready);
endinterface
`default_nettype wire

// File: rtl/frame_pattern_generator.sv
`default_nettype none
// ============================================================================
// frame_pattern_generator : raster test-pattern source (bars / ramp / checker / solid)
// Revision: 1.0
// ============================================================================
module frame_pattern_generator #(
   parameter int PIXEL_BITS = 8,
   parameter int NUM_PLANES = 3,
   parameter int DIM_BITS   = 13
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             soft_reset,
   input  logic                             enable,
   input  logic [1:0]                       mode,
   input  logic [DIM_BITS-1:0]              width,
   input  logic [DIM_BITS-1:0]              height,
   input  logic [NUM_PLANES*PIXEL_BITS-1:0] solid_color,
   frame_pattern_generator_if.master        m_axis,
   output logic [DIM_BITS-1:0]              row_count,
   output logic [DIM_BITS-1:0]              col_count,
   output logic [15:0]                      frame_count,
   output logic [15:0]                      core_id
);
   localparam int              DATA_BITS = NUM_PLANES * PIXEL_BITS;
   localparam logic [0:0]      ST_IDLE   = 1'b0;
   localparam logic [0:0]      ST_RUN    = 1'b1;
   localparam logic [15:0]     CORE_ID   = 16'h0DEC;
   localparam logic [DIM_BITS:0] ONE_EXT = 1;

   logic [0:0]           r_state, w_state;
   logic [1:0]           r_mode, w_mode;
   logic [DIM_BITS-1:0]  r_width, w_width, r_height, w_height;
   logic [DIM_BITS-1:0]  r_row, w_row, r_col, w_col;
   logic [DATA_BITS-1:0] r_solid, w_solid, r_data, w_data;
   logic [15:0]          r_frame, w_frame;
   logic                 r_valid, w_valid, r_last, w_last, r_user, w_user;
   logic                 w_load, w_present;

   logic                 w_xfer, w_start_ok, w_eol, w_eof;
   logic [DIM_BITS:0]    w_col_ext, w_bar1, w_bar2, w_bar3;
   logic [PIXEL_BITS-1:0] w_ramp;

   assign w_xfer     = r_valid && m_axis.m_ready;
   assign w_start_ok = enable && (width != '0) && (height != '0);
   assign w_eol      = (({1'b0, r_col} + ONE_EXT) == {1'b0, r_width});
   assign w_eof      = w_eol && (({1'b0, r_row} + ONE_EXT) == {1'b0, r_height});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_mode   <= '0;
         r_width  <= '0;
         r_height <= '0;
         r_solid  <= '0;
         r_row    <= '0;
         r_col    <= '0;
         r_frame  <= '0;
         r_data   <= '0;
         r_valid  <= 1'b0;
         r_last   <= 1'b0;
         r_user   <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_mode   <= w_mode;
         r_width  <= w_width;
         r_height <= w_height;
         r_solid  <= w_solid;
         r_row    <= w_row;
         r_col    <= w_col;
         r_frame  <= w_frame;
         r_data   <= w_data;
         r_valid  <= w_valid;
         r_last   <= w_last;
         r_user   <= w_user;
      end
   end

   // Config is only re-sampled on a frame start, so mid-frame input changes are ignored.
   always_comb begin
      w_state   = r_state;
      w_mode    = r_mode;
      w_width   = r_width;
      w_height  = r_height;
      w_solid   = r_solid;
      w_row     = r_row;
      w_col     = r_col;
      w_frame   = r_frame;
      w_valid   = r_valid;
      w_load    = 1'b0;
      w_present = 1'b0;
      if (soft_reset) begin
         w_state  = ST_IDLE;
         w_mode   = '0;
         w_width  = '0;
         w_height = '0;
         w_solid  = '0;
         w_row    = '0;
         w_col    = '0;
         w_frame  = '0;
         w_valid  = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start_ok) begin
                  w_state = ST_RUN;
                  w_load  = 1'b1;
               end
            end
            ST_RUN: begin
               if (w_xfer) begin
                  if (w_eof) begin
                     w_frame = r_frame + 16'd1;
                     if (w_start_ok) begin
                        w_load = 1'b1;
                     end else begin
                        w_state = ST_IDLE;
                        w_valid = 1'b0;
                     end
                  end else if (w_eol) begin
                     w_col     = '0;
                     w_row     = r_row + DIM_BITS'(1);
                     w_present = 1'b1;
                  end else begin
                     w_col     = r_col + DIM_BITS'(1);
                     w_present = 1'b1;
                  end
               end
            end
            default: w_state = ST_IDLE;
         endcase
         if (w_load) begin
            w_mode    = mode;
            w_width   = width;
            w_height  = height;
            w_solid   = solid_color;
            w_row     = '0;
            w_col     = '0;
            w_valid   = 1'b1;
            w_present = 1'b1;
         end
      end
   end

   // Pixel is evaluated on the next coordinates/config so it lands with them in the same register stage.
   always_comb begin
      w_col_ext = {1'b0, w_col};
      w_bar1    = {1'b0, w_width >> 2};
      w_bar2    = {1'b0, w_width >> 1};
      w_bar3    = w_bar1 + w_bar2;
      w_ramp    = PIXEL_BITS'(w_col) + PIXEL_BITS'(w_frame);
      w_data    = r_data;
      w_last    = r_last;
      w_user    = r_user;
      if (soft_reset) begin
         w_data = '0;
         w_last = 1'b0;
         w_user = 1'b0;
      end else if (w_present) begin
         w_data = '0;
         for (int p = 0; p < NUM_PLANES; p++) begin
            case (w_mode)
               2'd0: begin
                  if ((w_col_ext >= w_bar3) ||
                      (p == 0 && w_col_ext < w_bar1) ||
                      (p == 1 && w_col_ext >= w_bar1 && w_col_ext < w_bar2) ||
                      (p == 2 && w_col_ext >= w_bar2 && w_col_ext < w_bar3))
                     w_data[p*PIXEL_BITS +: PIXEL_BITS] = '1;
               end
               2'd1: w_data[p*PIXEL_BITS +: PIXEL_BITS] = w_ramp;
               2'd2: begin
                  if (w_col[3] ^ w_row[3])
                     w_data[p*PIXEL_BITS +: PIXEL_BITS] = '1;
               end
               default: w_data[p*PIXEL_BITS +: PIXEL_BITS] = w_solid[p*PIXEL_BITS +: PIXEL_BITS];
            endcase
         end
         w_last = (({1'b0, w_col} + ONE_EXT) == {1'b0, w_width});
         w_user = (w_row == '0) && (w_col == '0);
      end
   end

   assign m_axis.m_data  = r_data;
   assign m_axis.m_valid = r_valid;
   assign m_axis.m_last  = r_last;
   assign m_axis.m_user  = r_user;
   assign row_count      = r_row;
   assign col_count      = r_col;
   assign frame_count    = r_frame;
   assign core_id        = CORE_ID;
endmodule
`default_nettype wire

// File: tb/tb_frame_pattern_generator.sv
`default_nettype none
// ============================================================================
// tb_frame_pattern_generator : directed self-checking bench for frame_pattern_generator
// Revision: 1.0
// ============================================================================
module tb_frame_pattern_generator;
   logic        clk = 1'b0;
   logic        reset, soft_reset, enable;
   logic [1:0]  mode;
   logic [12:0] width, height;
   logic [23:0] solid_color;
   logic [12:0] row_count, col_count;
   logic [15:0] frame_count, core_id;

   frame_pattern_generator_if #(.DATA_BITS(24)) axis ();

   frame_pattern_generator #(
      .PIXEL_BITS (8),
      .NUM_PLANES (3),
      .DIM_BITS   (13)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .soft_reset  (soft_reset),
      .enable      (enable),
      .mode        (mode),
      .width       (width),
      .height      (height),
      .solid_color (solid_color),
      .m_axis      (axis),
      .row_count   (row_count),
      .col_count   (col_count),
      .frame_count (frame_count),
      .core_id     (core_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] data;
      logic        valid;
      logic        last;
      logic        user;
      logic [12:0] row;
      logic [12:0] col;
   } beat_t;

   beat_t       beats[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc, r, c, v, nvalid;
   logic [23:0] e;
   logic [23:0] bars [8] = '{24'h0000FF, 24'h0000FF, 24'h00FF00, 24'h00FF00,
                             24'hFF0000, 24'hFF0000, 24'hFFFFFF, 24'hFFFFFF};

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Samples at negedge; a beat is recorded when valid and the ready driven for the coming edge are both high.
   task automatic collect(input int max_beats, input int ready_pct, input int drop_idx,
                          input logic [12:0] new_width, output int cycles);
      beat_t b, held;
      logic  stalled;
      stalled = 1'b0;
      cycles  = 0;
      held    = '{default: '0};
      beats.delete();
      while (beats.size() < max_beats && cycles < max_beats * 4 + 100) begin
         @(negedge clk);
         cycles++;
         b.data  = axis.m_data;
         b.valid = axis.m_valid;
         b.last  = axis.m_last;
         b.user  = axis.m_user;
         b.row   = row_count;
         b.col   = col_count;
         if (stalled)
            check("stall_hold", {b.valid, b.data, b.last, b.user, b.row, b.col},
                                {held.valid, held.data, held.last, held.user, held.row, held.col});
         axis.m_ready = ($urandom_range(99) < ready_pct);
         if (b.valid && axis.m_ready) begin
            if (beats.size() == drop_idx) begin
               enable = 1'b0;
               width  = new_width;
            end
            beats.push_back(b);
         end
         stalled = b.valid && !axis.m_ready;
         held    = b;
      end
      check("beat_count", beats.size(), max_beats);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; soft_reset = 1'b0; enable = 1'b0; mode = 2'd0;
      width = '0; height = '0; solid_color = '0; axis.m_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", axis.m_valid, 0);
      check("rst_data", axis.m_data, 0);
      check("rst_last_user", {axis.m_last, axis.m_user}, 0);
      check("rst_rowcol", {row_count, col_count}, 0);
      check("rst_frame", frame_count, 0);
      check("core_id", core_id, 16'h0DEC);
      reset = 1'b0;
      @(negedge clk);

      // Colour bars, 8x2
      mode = 2'd0; width = 13'd8; height = 13'd2; enable = 1'b1;
      collect(16, 100, 1, 13'd8, cyc);
      foreach (beats[i]) begin
         check("bars_data", beats[i].data, bars[i % 8]);
         check("bars_user_last", {beats[i].user, beats[i].last}, {i == 0, (i % 8) == 7});
      end
      @(negedge clk);
      check("bars_stop_valid", axis.m_valid, 0);
      check("bars_frame", frame_count, 1);

      // Checkerboard with random backpressure, 32x20
      mode = 2'd2; width = 13'd32; height = 13'd20; enable = 1'b1;
      collect(640, 50, 0, 13'd32, cyc);
      foreach (beats[i]) begin
         r = i / 32;
         c = i % 32;
         e = (((c / 8) % 2) != ((r / 8) % 2)) ? 24'hFFFFFF : 24'h000000;
         check("checker_beat", {beats[i].data, beats[i].last, beats[i].user, beats[i].row, beats[i].col},
                               {e, c == 31, i == 0, 13'(r), 13'(c)});
      end
      axis.m_ready = 1'b1;
      @(negedge clk);
      check("checker_stop_valid", axis.m_valid, 0);
      check("checker_frame", frame_count, 2);

      // Soft reset outranks enable
      soft_reset = 1'b1; enable = 1'b1; mode = 2'd3; width = 13'd8; height = 13'd4;
      solid_color = 24'h123456;
      @(negedge clk);
      check("soft_rst_valid", axis.m_valid, 0);
      check("soft_rst_frame", frame_count, 0);
      soft_reset = 1'b0;

      // Enable drop and width change at pixel (1,3) of an 8x4 solid frame
      collect(32, 100, 11, 13'd16, cyc);
      foreach (beats[i])
         check("solid_data", beats[i].data, 24'h123456);
      check("drop_row7_last", {beats[7].last, beats[7].row, beats[7].col}, {1'b1, 13'd0, 13'd7});
      check("drop_final", {beats[31].last, beats[31].row, beats[31].col}, {1'b1, 13'd3, 13'd7});
      @(negedge clk);
      check("drop_stop_valid", axis.m_valid, 0);
      check("drop_frame", frame_count, 1);

      // Ramp continuity across two back-to-back 4x1 frames
      soft_reset = 1'b1;
      @(negedge clk);
      soft_reset = 1'b0; mode = 2'd1; width = 13'd4; height = 13'd1; enable = 1'b1;
      collect(8, 100, 4, 13'd4, cyc);
      check("ramp_no_gap", cyc, 8);
      foreach (beats[i]) begin
         v = (i % 4) + (i / 4);
         e = {3{8'(v)}};
         check("ramp_data", beats[i].data, e);
         check("ramp_user_last", {beats[i].user, beats[i].last}, {(i % 4) == 0, (i % 4) == 3});
      end
      @(negedge clk);
      check("ramp_stop_valid", axis.m_valid, 0);
      check("ramp_frame", frame_count, 2);

      // Async reset at pixel (2,5) of an 8x4 frame
      mode = 2'd0; width = 13'd8; height = 13'd4; enable = 1'b1;
      collect(21, 100, 1000, 13'd8, cyc);
      @(negedge clk);
      check("areset_at", {axis.m_valid, row_count, col_count}, {1'b1, 13'd2, 13'd5});
      #2 reset = 1'b1;
      #1;
      check("areset_valid", axis.m_valid, 0);
      check("areset_data", {axis.m_data, axis.m_last, axis.m_user}, 0);
      check("areset_rowcol_frame", {row_count, col_count, frame_count}, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("areset_restart", {axis.m_valid, axis.m_user, row_count, col_count, frame_count},
                              {1'b1, 1'b1, 13'd0, 13'd0, 16'd0});
      enable = 1'b0;
      repeat (40) @(negedge clk);
      check("areset_frame_done", {axis.m_valid, frame_count}, {1'b0, 16'd1});

      // Zero width holds off the start
      mode = 2'd3; solid_color = 24'hABCDEF; width = 13'd0; height = 13'd4; enable = 1'b1;
      nvalid = 0;
      repeat (100) begin
         @(negedge clk);
         if (axis.m_valid) nvalid++;
      end
      check("zero_width_idle", nvalid, 0);
      width = 13'd4;
      @(negedge clk);
      check("zero_width_start", {axis.m_valid, axis.m_user, axis.m_data}, {1'b1, 1'b1, 24'hABCDEF});
      enable = 1'b0;
      repeat (20) @(negedge clk);
      check("zero_width_done", {axis.m_valid, frame_count}, {1'b0, 16'd2});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/frame_pattern_generator.md
# frame_pattern_generator

Parametrised test-pattern source for the video pipeline, emitting one packed multi-plane pixel per beat on an AXI-Stream-style master port with start-of-frame (`m_user`) and end-of-line (`m_last`) markers. It succeeds the byte-serial colour-bar generator with:

- a configurable pixel width and plane count;
- four pattern modes;
- frame-boundary enable/config latching;
- a frame counter.

It sits in front of the VDMA/display path as the bring-up and loopback stimulus.

## Interface
- `PIXEL_BITS`, 8, bits per plane.
- `NUM_PLANES`, 3, planes per pixel; plane 0 in LSBs.
- `DIM_BITS`, 13, width of height/width/row/col fields.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `soft_reset`  in  1  synchronous clear, same effect as `reset`.
- `enable`  in  1  run request.
- `mode`  in  2  0 colour bars, 1 moving ramp, 2 checkerboard, 3 solid.
- `width`, `height`  in  DIM_BITS each  frame size in pixels/lines.
- `solid_color`  in  NUM_PLANES*PIXEL_BITS  mode-3 pixel value.
- `m_data`  out  NUM_PLANES*PIXEL_BITS  pixel.
- `m_valid`  out  1  beat valid.
- `m_ready`  in  1  sink ready.
- `m_last`  out  1  last pixel of line.
- `m_user`  out  1  first pixel of frame.
- `row_count`, `col_count`  out  DIM_BITS each  coordinates of the presented pixel.
- `frame_count`  out  16  completed frames, wraps.
- `core_id`  out  16  constant 16'h0DEC.

## Operation
- States:
  - IDLE: `m_valid`=0.
  - RUN: presenting pixels.
- IDLE→RUN on an edge with `enable`=1, `width`≠0 and `height`≠0.
  - At that edge, latch `mode`, `width`, `height` and `solid_color`.
  - Load row=col=0.
- Latched config is held for the whole frame; input changes mid-frame are ignored.
- A beat transfers when `m_valid` && `m_ready`. On transfer the next pixel is registered; raster order is col fastest, then row.
- `m_last` = (col == W-1). `m_user` = (row == 0 && col == 0).
- End of frame is the transfer of (H-1, W-1):
  - `frame_count` += 1, mod 2^16.
  - If `enable`=1 and the new `width`/`height` are nonzero: re-latch config and present (0,0) next cycle with no gap.
  - Otherwise go to IDLE.
- Deasserting `enable` mid-frame does not truncate the frame; the frame always completes.
- Patterns, where W = latched width and c, r = col, row:
  - Mode 0, colour bars:
    - c < W>>2: plane 0 = all-ones.
    - c < W>>1: plane 1 = all-ones.
    - c < (W>>1)+(W>>2): plane 2 = all-ones.
    - Otherwise: all planes all-ones (white).
    - Planes not lit are 0. A bar whose plane index ≥ NUM_PLANES outputs all-zero.
  - Mode 1, moving ramp: every plane = (c + frame_count) mod 2^PIXEL_BITS.
  - Mode 2, checkerboard: all planes all-ones if c[3]^r[3], else 0 (8×8 squares).
  - Mode 3, solid: `solid_color`.
- Arithmetic:
  - Boundary compares use DIM_BITS+1 bits; no overflow for W ≤ 2^DIM_BITS-1.
  - Ramp sum is truncated to PIXEL_BITS.
- `reset` / `soft_reset` clear all of the following, and abort any frame in flight:
  - state→IDLE;
  - `m_data`, `m_valid`, `m_last`, `m_user` = 0;
  - row, col, `frame_count` = 0.
- `soft_reset` has priority over `enable`.

## Timing
- All outputs except `core_id` are registered.
- Reset values are 0, including `frame_count`. `core_id` is constant.
- Start latency: first beat is valid in the cycle after the IDLE→RUN edge.
- Throughput: one pixel per cycle while `m_ready`=1.
- Stall rule: while `m_valid`=1 and `m_ready`=0, `m_data`, `m_last`, `m_user`, `row_count` and `col_count` hold stable.
- `m_valid` never drops without a transfer, except on reset.
- `m_valid` does not depend combinationally on `m_ready`.
- Stop: `m_valid` falls in the cycle after the final transfer of the frame.
- Async `reset` forces outputs to 0 immediately, without waiting for a clock.
- `frame_count` updates on the final-transfer edge. The ramp's first pixel of the next frame uses the new value.

## Test plan
- **Colour bars:** W=8, H=2, mode 0, `m_ready`=1, NUM_PLANES=3, 8-bit.
  - Required data per line: 0x0000FF×2, 0x00FF00×2, 0xFF0000×2, 0xFFFFFF×2, repeated for both lines.
  - `m_user` on beat 1 only; `m_last` on beats 8 and 16.
- **Random backpressure:** `m_ready` ~50%, mode 2, W=32, H=20.
  - Exactly 640 transfers per frame, each matching the reference model.
  - Outputs held stable across every stall cycle.
- **Enable drop mid-frame:** drop `enable` at pixel (1,3), W=8, H=4.
  - The frame completes with 32 transfers.
  - `m_valid`=0 the cycle after (3,7); `frame_count`=1.
  - Change `width` mid-frame: no effect until the next frame.
- **Ramp continuity:** mode 1, W=4, H=1, two back-to-back frames.
  - Planes read 0,1,2,3 then 1,2,3,4.
  - No idle cycle between frames; `m_user` on beats 1 and 5.
- **Async reset mid-frame:** assert `reset` between edges at pixel (2,5).
  - Outputs are 0 before the next edge.
  - After release with `enable`=1, the first beat is (0,0) with `m_user`=1 and `frame_count`=0.
- **Zero size:** `width`=0 with `enable`=1.
  - `m_valid` stays 0 for 100 cycles.
  - Setting `width`=4 then starts a frame one cycle after the latching edge.
